// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// dmem_arbiter_if : core/host request ports and data-memory port of the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_SIZE = 10
);
  logic                 core_req;
  logic                 core_we;
  logic [31:0]          core_addr;
  logic [31:0]          core_wdata;
  logic                 core_gnt;
  logic                 core_rvalid;
  logic [31:0]          core_rdata;

  logic                 host_req;
  logic                 host_we;
  logic [31:0]          host_addr;
  logic [31:0]          host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [31:0]          host_rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  logic                 addr_err;

  // Arbiter view
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output addr_err
  );

  // Requester + memory view
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  addr_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : core/host arbiter for the single data memory.
// Macro DMEM_ARB_RR_EN selects round-robin; default is fixed core priority.
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_SIZE = 10
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dmem_arbiter_if.slave     bus
);

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_HOST = 1'b1
  } gnt_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } own_e;

  gnt_e        r_last_gnt, w_last_gnt_nxt;
  own_e        r_rd_owner, w_rd_owner_nxt;
  logic        r_rd_oor,   w_rd_oor_nxt;
  logic        r_addr_err, w_addr_err_nxt;

  logic        w_core_win;
  logic        w_host_win;
  logic        w_any_win;
  logic        w_sel_we;
  logic        w_in_range;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_unused_ok;

  // Winner selection; rst gates every grant.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    w_core_win = bus.core_req && !rst && (!bus.host_req || (r_last_gnt == GNT_HOST));
`else
    w_core_win = bus.core_req && !rst;
`endif
    w_host_win = bus.host_req && !rst && !w_core_win;
    w_any_win  = w_core_win || w_host_win;
  end

  assign w_sel_addr  = w_host_win ? bus.host_addr  : bus.core_addr;
  assign w_sel_wdata = w_host_win ? bus.host_wdata : bus.core_wdata;
  assign w_sel_we    = w_host_win ? bus.host_we    : bus.core_we;
  assign w_in_range  = (w_sel_addr[31:ADDR_SIZE+2] == '0);
  assign w_unused_ok = &{1'b0, w_sel_addr[1:0]};

  assign bus.core_gnt  = w_core_win;
  assign bus.host_gnt  = w_host_win;
  assign bus.mem_en    = w_any_win;
  assign bus.mem_we    = w_any_win && w_sel_we && w_in_range;
  assign bus.mem_addr  = w_sel_addr[ADDR_SIZE+1:2];
  assign bus.mem_wdata = w_sel_wdata;

  always_comb begin
    w_last_gnt_nxt = r_last_gnt;
    w_rd_owner_nxt = OWN_NONE;
    w_rd_oor_nxt   = 1'b0;
    w_addr_err_nxt = r_addr_err;
    if (w_any_win) begin
      w_last_gnt_nxt = w_host_win ? GNT_HOST : GNT_CORE;
      if (!w_in_range) begin
        w_addr_err_nxt = 1'b1;
      end
      if (!w_sel_we) begin
        w_rd_owner_nxt = w_host_win ? OWN_HOST : OWN_CORE;
        w_rd_oor_nxt   = !w_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= GNT_HOST;
      r_rd_owner <= OWN_NONE;
      r_rd_oor   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_last_gnt <= w_last_gnt_nxt;
      r_rd_owner <= w_rd_owner_nxt;
      r_rd_oor   <= w_rd_oor_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  // Read return is masked during rst so a read granted just before reset never surfaces.
  assign bus.core_rvalid = (r_rd_owner == OWN_CORE) && !rst;
  assign bus.host_rvalid = (r_rd_owner == OWN_HOST) && !rst;
  assign bus.core_rdata  = (bus.core_rvalid && !r_rd_oor) ? bus.mem_rdata : 32'd0;
  assign bus.host_rdata  = (bus.host_rvalid && !r_rd_oor) ? bus.mem_rdata : 32'd0;
  assign bus.addr_err    = r_addr_err && !rst;

endmodule

`default_nettype wire
